// File: rtl/uart_frame_pkg.sv
// Shared constants and state types for the framed UART receiver.
// Used by uart_rx and uart_frame_rx; UART_FRAME_RX_STATS_EN enables the frame/error counters.
package uart_frame_pkg;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;
    localparam int FRAME_PAYLOAD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    typedef enum logic [2:0] {
        HUNT_A5,
        HUNT_5A,
        B3,
        B2,
        B1,
        B0
    } parse_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// Bit-level 8N1 UART receiver: synchronizes the line, rejects short start glitches,
// samples mid-bit and emits a byte with a same-cycle valid or stop-error pulse.
module uart_rx
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stop_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_t        state, state_next;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_pin};
        end
    end

    assign rx_s = sync_q[1];

    // START waits half a bit so every later sample lands mid-bit.
    assign tick = (state == START) ? (clk_cnt == HALF_M1) : (clk_cnt == FULL_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rx_s) state_next = START;
            START:     if (tick) state_next = rx_s ? IDLE : DATA;
            DATA:      if (tick && bit_idx == 3'd7) state_next = STOP;
            STOP:      if (tick) state_next = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shift_q <= '0;
        end else begin
            if (state == IDLE || tick) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + CNT_W'(1);
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && tick) begin
                shift_q <= {rx_s, shift_q[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = (state == STOP) && tick && rx_s;
    assign stop_err   = (state == STOP) && tick && !rx_s;

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: hunts for A5 5A, collects a 4-byte payload and aborts on
// stop-bit errors or inter-byte timeout. Define UART_FRAME_RX_STATS_EN for live counters.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx_pin,
    output logic [31:0] o_frame_data,
    output logic        o_frame_valid,
    output logic        o_frame_err,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_err_cnt
);

    localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD_RATE;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam int PAYLOAD_W      = 8 * (FRAME_PAYLOAD_BYTES - 1);

    logic [7:0]           rx_byte;
    logic                 byte_valid;
    logic                 stop_err;
    parse_state_t         pstate, pstate_next;
    logic [TO_W-1:0]      to_cnt;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 timeout;
    logic                 frame_load;
    logic                 err_next;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_pin     (uart_rx_pin),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .stop_err   (stop_err)
    );

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout    = (pstate != HUNT_A5) && (to_cnt == TO_LAST) && !byte_valid && !stop_err;
    assign frame_load = byte_valid && (pstate == B0);
    assign err_next   = stop_err || timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate <= HUNT_A5;
        end else begin
            pstate <= pstate_next;
        end
    end

    always_comb begin
        pstate_next = pstate;
        if (err_next) begin
            pstate_next = HUNT_A5;
        end else if (byte_valid) begin
            case (pstate)
                HUNT_A5: if (rx_byte == SYNC0) pstate_next = HUNT_5A;
                HUNT_5A: begin
                    if (rx_byte == SYNC1) begin
                        pstate_next = B3;
                    end else if (rx_byte != SYNC0) begin
                        pstate_next = HUNT_A5;
                    end
                end
                B3:      pstate_next = B2;
                B2:      pstate_next = B1;
                B1:      pstate_next = B0;
                B0:      pstate_next = HUNT_A5;
                default: pstate_next = HUNT_A5;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt        <= '0;
            payload_q     <= '0;
            o_frame_data  <= '0;
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            if (pstate == HUNT_A5 || byte_valid || stop_err) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (byte_valid && (pstate == B3 || pstate == B2 || pstate == B1)) begin
                payload_q <= {payload_q[PAYLOAD_W-9:0], rx_byte};
            end
            if (frame_load) begin
                o_frame_data <= {payload_q, rx_byte};
            end
            o_frame_valid <= frame_load;
            o_frame_err   <= err_next;
        end
    end

`ifdef UART_FRAME_RX_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (frame_load) frame_cnt_q <= sat_inc16(frame_cnt_q);
            if (err_next)   err_cnt_q   <= sat_inc16(err_cnt_q);
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_err_cnt   = err_cnt_q;
`else
    assign o_frame_cnt = '0;
    assign o_err_cnt   = '0;
`endif

endmodule
